// File: rtl/ahb_pkg.sv
// Shared AHB encodings used by the arbiter and the bus masters.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        HBURST_SINGLE = 2'd0,
        HBURST_INCR   = 2'd1,
        HBURST_INCR4  = 2'd2,
        HBURST_INCR8  = 2'd3
    } hburst_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1,
        HRESP_RETRY = 2'd2,
        HRESP_SPLIT = 2'd3
    } hresp_e;

    // SEQ beats that follow the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
    function automatic logic [2:0] burst_seq_beats(input logic [1:0] hburst);
        logic [2:0] beats;
        beats = 3'd0;
        if (hburst == HBURST_INCR4) beats = 3'd3;
        if (hburst == HBURST_INCR8) beats = 3'd7;
        return beats;
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, ptr itself last.
module ahb_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned MW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [MW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [MW-1:0] idx,
    output logic          valid
);

    logic [MW-1:0] cand;

    // Scan ptr+1 .. ptr+N modulo N and keep the first hit.
    always_comb begin
        pick  = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand = MW'((32'(ptr) + off) % N);
            if (!valid && req[cand]) begin
                valid      = 1'b1;
                idx        = cand;
                pick[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Central AHB arbiter: round-robin with lock support and fixed-burst protection.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   i_hclk,
    input  logic                   i_hreset_n,
    input  logic [NUM_MASTERS-1:0] i_hbusreq,
    input  logic [NUM_MASTERS-1:0] i_hlock,
    input  logic [1:0]             i_htrans,
    input  logic [1:0]             i_hburst,
    input  logic                   i_hready,
    input  logic [1:0]             i_hresp,
    output logic [NUM_MASTERS-1:0] o_hgrant,
    output logic [MW-1:0]          o_hmaster,
    output logic [MW-1:0]          o_hmaster_data,
    output logic                   o_hmastlock
);

    localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          gidx_q, gidx_d;
    logic [MW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [2:0]             beat_cnt_q, beat_cnt_d;
    logic [MW-1:0]          hmaster_q, hmaster_data_q;
    logic                   hmastlock_q;

    logic                   acc;
    logic                   arb;
    logic [NUM_MASTERS-1:0] pick;
    logic [MW-1:0]          pick_idx;
    logic                   pick_valid;

    assign acc = i_hready;

    ahb_rr_pick #(
        .N  (NUM_MASTERS),
        .MW (MW)
    ) u_rr_pick (
        .req   (i_hbusreq),
        .ptr   (rr_ptr_q),
        .pick  (pick),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Remaining SEQ beats of the fixed burst in flight; an error response drops protection.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (acc && i_htrans == HTRANS_NONSEQ && burst_seq_beats(i_hburst) != 3'd0) begin
            beat_cnt_d = burst_seq_beats(i_hburst);
        end else if (acc && i_htrans == HTRANS_SEQ && beat_cnt_q != 3'd0) begin
            beat_cnt_d = beat_cnt_q - 3'd1;
        end else if (!i_hready && i_hresp != HRESP_OKAY) begin
            beat_cnt_d = 3'd0;
        end
    end

    assign arb = acc && (beat_cnt_d == 3'd0);

    // Next grant: locked owner keeps the bus, else round-robin, else the default master.
    always_comb begin
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        if (arb) begin
            if (i_hlock[gidx_q] && i_hbusreq[gidx_q]) begin
                rr_ptr_d = gidx_q;
            end else if (pick_valid) begin
                grant_d  = pick;
                gidx_d   = pick_idx;
                rr_ptr_d = pick_idx;
            end else begin
                grant_d = DEF_GRANT;
                gidx_d  = DEF_IDX;
            end
        end
    end

    // Arbitration state and burst counter.
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            grant_q    <= DEF_GRANT;
            gidx_q     <= DEF_IDX;
            rr_ptr_q   <= DEF_IDX;
            beat_cnt_q <= 3'd0;
        end else begin
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Address/data phase ownership advances only when a transfer is accepted.
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            hmaster_q      <= DEF_IDX;
            hmaster_data_q <= DEF_IDX;
            hmastlock_q    <= 1'b0;
        end else if (acc) begin
            hmaster_q      <= gidx_q;
            hmaster_data_q <= hmaster_q;
            hmastlock_q    <= i_hlock[gidx_q];
        end
    end

    assign o_hgrant       = grant_q;
    assign o_hmaster      = hmaster_q;
    assign o_hmaster_data = hmaster_data_q;
    assign o_hmastlock    = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter: directed scenarios followed by random traffic.
module tb_ahb_arbiter;
    import ahb_pkg::*;

    localparam int N = 4;

    logic         i_hclk = 1'b0;
    logic         i_hreset_n;
    logic [N-1:0] i_hbusreq;
    logic [N-1:0] i_hlock;
    logic [1:0]   i_htrans;
    logic [1:0]   i_hburst;
    logic         i_hready;
    logic [1:0]   i_hresp;
    logic [N-1:0] o_hgrant;
    logic [1:0]   o_hmaster;
    logic [1:0]   o_hmaster_data;
    logic         o_hmastlock;

    ahb_arbiter #(
        .NUM_MASTERS    (N),
        .DEFAULT_MASTER (0)
    ) dut (
        .i_hclk         (i_hclk),
        .i_hreset_n     (i_hreset_n),
        .i_hbusreq      (i_hbusreq),
        .i_hlock        (i_hlock),
        .i_htrans       (i_htrans),
        .i_hburst       (i_hburst),
        .i_hready       (i_hready),
        .i_hresp        (i_hresp),
        .o_hgrant       (o_hgrant),
        .o_hmaster      (o_hmaster),
        .o_hmaster_data (o_hmaster_data),
        .o_hmastlock    (o_hmastlock)
    );

    always #5 i_hclk = ~i_hclk;

    typedef struct {
        logic [N-1:0] grant;
        logic [1:0]   master;
        logic [1:0]   mdata;
        logic         mlock;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: plain integers for owner indices and remaining beats.
    int m_grant, m_master, m_mdata, m_beats, m_rr;
    bit m_lock;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        m_grant  = 0;
        m_master = 0;
        m_mdata  = 0;
        m_lock   = 1'b0;
        m_beats  = 0;
        m_rr     = 0;
    endfunction

    function automatic void model_edge(logic [N-1:0] req, logic [N-1:0] lk, logic [1:0] tr,
                                       logic [1:0] bu, logic rdy, logic [1:0] rsp);
        int  nb = m_beats;
        int  g  = m_grant;
        bit  found = 1'b0;
        if (rdy && tr == 2'd2 && bu == 2'd2)               nb = 3;
        else if (rdy && tr == 2'd2 && bu == 2'd3)          nb = 7;
        else if (rdy && tr == 2'd3 && m_beats > 0)         nb = m_beats - 1;
        else if (!rdy && rsp != 2'd0)                      nb = 0;
        if (rdy) begin
            m_mdata  = m_master;
            m_master = g;
            m_lock   = lk[g];
        end
        if (rdy && nb == 0) begin
            if (lk[g] && req[g]) begin
                m_rr = g;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c = (m_rr + k) % N;
                    if (!found && req[c]) begin
                        found   = 1'b1;
                        m_grant = c;
                    end
                end
                if (found) m_rr = m_grant;
                else       m_grant = 0;
            end
        end
        m_beats = nb;
    endfunction

    // Drive one cycle of bus inputs, predict the post-edge outputs, advance to edge+2.
    task automatic step(logic [N-1:0] req, logic [N-1:0] lk, logic [1:0] tr, logic [1:0] bu,
                        logic rdy, logic [1:0] rsp);
        exp_t e;
        i_hbusreq = req;
        i_hlock   = lk;
        i_htrans  = tr;
        i_hburst  = bu;
        i_hready  = rdy;
        i_hresp   = rsp;
        model_edge(req, lk, tr, bu, rdy, rsp);
        e.grant  = N'(1) << m_grant;
        e.master = 2'(m_master);
        e.mdata  = 2'(m_mdata);
        e.mlock  = m_lock;
        sb.push_back(e);
        @(posedge i_hclk);
        #2;
    endtask

    task automatic do_reset();
        i_hreset_n = 1'b0;
        i_hbusreq  = '0;
        i_hlock    = '0;
        i_htrans   = HTRANS_IDLE;
        i_hburst   = HBURST_SINGLE;
        i_hready   = 1'b1;
        i_hresp    = HRESP_OKAY;
        model_reset();
        repeat (2) begin
            @(posedge i_hclk);
            #2;
            check("reset_grant", o_hgrant, 4'b0001);
            check("reset_master", o_hmaster, 0);
            check("reset_mlock", o_hmastlock, 0);
        end
        i_hreset_n = 1'b1;
    endtask

    // Monitor: compare DUT outputs one step after each edge that has a prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge i_hclk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_grant", o_hgrant, e.grant);
                check("sb_master", o_hmaster, e.master);
                check("sb_mdata", o_hmaster_data, e.mdata);
                check("sb_mlock", o_hmastlock, e.mlock);
            end
        end
    end

    initial begin
        logic [N-1:0] rr_grant [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
        int           rr_mast  [6] = '{0, 1, 2, 3, 1, 2};
        logic [N-1:0] rq, lk;
        logic         rdy;
        logic [1:0]   rsp;

        i_hreset_n = 1'b0;
        #2;
        do_reset();

        // Idle bus stays with the default master.
        repeat (3) begin
            step(4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
            check("idle_grant", o_hgrant, 4'b0001);
            check("idle_master", o_hmaster, 0);
            check("idle_mlock", o_hmastlock, 0);
        end

        // Round-robin among masters 1..3.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(4'b1110, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, HRESP_OKAY);
            check("rr_grant", o_hgrant, rr_grant[i]);
            check("rr_master", o_hmaster, rr_mast[i]);
        end

        // INCR4 holds the grant until the third SEQ is accepted.
        do_reset();
        step(4'b0110, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
        check("incr4_first", o_hgrant, 4'b0010);
        step(4'b0110, 4'b0000, HTRANS_NONSEQ, HBURST_INCR4, 1'b1, HRESP_OKAY);
        check("incr4_nonseq", o_hgrant, 4'b0010);
        repeat (2) begin
            step(4'b0110, 4'b0000, HTRANS_SEQ, HBURST_INCR4, 1'b1, HRESP_OKAY);
            check("incr4_seq", o_hgrant, 4'b0010);
        end
        step(4'b0110, 4'b0000, HTRANS_SEQ, HBURST_INCR4, 1'b1, HRESP_OKAY);
        check("incr4_handover", o_hgrant, 4'b0100);

        // Same burst with two wait states mid-burst.
        do_reset();
        step(4'b0110, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
        step(4'b0110, 4'b0000, HTRANS_NONSEQ, HBURST_INCR4, 1'b1, HRESP_OKAY);
        step(4'b0110, 4'b0000, HTRANS_SEQ, HBURST_INCR4, 1'b1, HRESP_OKAY);
        repeat (2) begin
            step(4'b0110, 4'b0000, HTRANS_SEQ, HBURST_INCR4, 1'b0, HRESP_OKAY);
            check("wait_grant", o_hgrant, 4'b0010);
            check("wait_master", o_hmaster, 1);
        end
        step(4'b0110, 4'b0000, HTRANS_SEQ, HBURST_INCR4, 1'b1, HRESP_OKAY);
        check("wait_seq2", o_hgrant, 4'b0010);
        step(4'b0110, 4'b0000, HTRANS_SEQ, HBURST_INCR4, 1'b1, HRESP_OKAY);
        check("wait_handover", o_hgrant, 4'b0100);

        // Locked master 2 keeps the bus over master 0 until the lock drops.
        do_reset();
        step(4'b0100, 4'b0100, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
        check("lock_acquire", o_hgrant, 4'b0100);
        repeat (5) begin
            step(4'b0101, 4'b0100, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, HRESP_OKAY);
            check("lock_grant", o_hgrant, 4'b0100);
            check("lock_mlock", o_hmastlock, 1);
        end
        step(4'b0101, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, HRESP_OKAY);
        check("lock_release", o_hgrant, 4'b0001);

        // ERROR aborts the INCR8 burst; next accepted edge re-arbitrates.
        do_reset();
        step(4'b1000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
        check("err_first", o_hgrant, 4'b1000);
        step(4'b1000, 4'b0000, HTRANS_NONSEQ, HBURST_INCR8, 1'b1, HRESP_OKAY);
        step(4'b1000, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1'b1, HRESP_OKAY);
        step(4'b1000, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1'b1, HRESP_OKAY);
        step(4'b1010, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1'b0, HRESP_ERROR);
        check("err_hold", o_hgrant, 4'b1000);
        step(4'b0010, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
        check("err_rearb", o_hgrant, 4'b0010);
        check("err_master", o_hmaster, 3);

        // Asynchronous reset mid-cycle.
        #1;
        i_hreset_n = 1'b0;
        #1;
        check("async_grant", o_hgrant, 4'b0001);
        check("async_master", o_hmaster, 0);
        check("async_mdata", o_hmaster_data, 0);
        check("async_mlock", o_hmastlock, 0);
        model_reset();
        @(posedge i_hclk);
        #2;
        i_hreset_n = 1'b1;

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            rq  = N'($urandom);
            lk  = N'($urandom) & N'($urandom) & rq;
            rdy = ($urandom_range(0, 3) != 0);
            rsp = HRESP_OKAY;
            if (!rdy && $urandom_range(0, 2) == 0) rsp = 2'($urandom_range(1, 3));
            step(rq, lk, 2'($urandom), 2'($urandom), rdy, rsp);
        end

        @(posedge i_hclk);
        #2;
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
